ast_width_downsizer: RTL and testbench

- Avalon-ST width downsizer. It takes a wide input stream (default 128-bit) and produces a narrow output stream (default 64-bit).
- It is the reverse-direction counterpart of the team's 64→128 upsizing converter. Chaining the two must reproduce the original packet stream byte for byte.
- Each accepted input word is split into up to DATA_IN_W/DATA_OUT_W output beats. Channel, SOP, EOP and empty are carried through.

---
 rtl/ast_width_downsizer.sv | 109 ++++++++++
 tb/tb_ast_width_downsizer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ast_width_downsizer.sv
// Avalon-ST width downsizer: splits each wide input word into up to K narrow
// MSB-first beats, carrying SOP/EOP/empty/channel through.
module ast_width_downsizer #(
    parameter int DATA_IN_W   = 128,
    parameter int DATA_OUT_W  = 64,
    parameter int CHANNEL_W   = 10,
    parameter int EMPTY_IN_W  = (DATA_IN_W > 8) ? $clog2(DATA_IN_W / 8) : 1,
    parameter int EMPTY_OUT_W = (DATA_OUT_W > 8) ? $clog2(DATA_OUT_W / 8) : 1
) (
    input  logic                   clk_i,
    input  logic                   arst_n_i,
    input  logic [DATA_IN_W-1:0]   ast_data_i,
    input  logic                   ast_startofpacket_i,
    input  logic                   ast_endofpacket_i,
    input  logic                   ast_valid_i,
    input  logic [EMPTY_IN_W-1:0]  ast_empty_i,
    input  logic [CHANNEL_W-1:0]   ast_channel_i,
    output logic                   ast_ready_o,
    output logic [DATA_OUT_W-1:0]  ast_data_o,
    output logic                   ast_startofpacket_o,
    output logic                   ast_endofpacket_o,
    output logic                   ast_valid_o,
    output logic [EMPTY_OUT_W-1:0] ast_empty_o,
    output logic [CHANNEL_W-1:0]   ast_channel_o,
    input  logic                   ast_ready_i
);

    localparam int K         = DATA_IN_W / DATA_OUT_W;
    localparam int IDX_W     = $clog2(K);
    localparam int BYTES_OUT = DATA_OUT_W / 8;

    typedef enum logic {IDLE, SEND} state_t;

    state_t                 state, state_nxt;
    logic [IDX_W-1:0]       idx, idx_nxt, last, last_nxt;
    logic [DATA_IN_W-1:0]   word_data, word_shifted;
    logic                   word_sop, word_eop;
    logic [EMPTY_OUT_W-1:0] word_empty, empty_nxt;
    logic [CHANNEL_W-1:0]   word_channel;
    logic                   run;
    logic                   at_last, in_fire, out_fire;

    // run keeps ast_ready_o low while reset is held and for the first edge after it
    assign at_last     = (idx == last);
    assign ast_valid_o = (state == SEND);
    assign ast_ready_o = run & ((state == IDLE) | (at_last & ast_ready_i));
    assign in_fire     = ast_valid_i & ast_ready_o;
    assign out_fire    = ast_valid_o & ast_ready_i;

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        if (in_fire) begin
            state_nxt = SEND;
            idx_nxt   = '0;
        end else if (out_fire) begin
            if (at_last) state_nxt = IDLE;
            else         idx_nxt   = idx + 1'b1;
        end
    end

    // Whole output beats covered by the trailing empty bytes are dropped
    always_comb begin
        last_nxt  = IDX_W'(K - 1);
        empty_nxt = '0;
        if (ast_endofpacket_i) begin
            last_nxt  = IDX_W'(K - 1 - int'(ast_empty_i) / BYTES_OUT);
            empty_nxt = EMPTY_OUT_W'(int'(ast_empty_i) % BYTES_OUT);
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state <= IDLE;
            idx   <= '0;
            run   <= 1'b0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            run   <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            word_data    <= '0;
            word_sop     <= 1'b0;
            word_eop     <= 1'b0;
            word_empty   <= '0;
            word_channel <= '0;
            last         <= '0;
        end else if (in_fire) begin
            word_data    <= ast_data_i;
            word_sop     <= ast_startofpacket_i;
            word_eop     <= ast_endofpacket_i;
            word_empty   <= empty_nxt;
            word_channel <= ast_channel_i;
            last         <= last_nxt;
        end
    end

    assign word_shifted        = word_data << (idx * DATA_OUT_W);
    assign ast_data_o          = ast_valid_o ? word_shifted[DATA_IN_W-1 -: DATA_OUT_W] : '0;
    assign ast_startofpacket_o = ast_valid_o & word_sop & (idx == '0);
    assign ast_endofpacket_o   = ast_valid_o & word_eop & at_last;
    assign ast_empty_o         = ast_endofpacket_o ? word_empty : '0;
    assign ast_channel_o       = ast_valid_o ? word_channel : '0;

endmodule

// File: tb/tb_ast_width_downsizer.sv
// Scoreboard bench for ast_width_downsizer: expected beats are queued when a
// word is accepted and compared as the DUT emits them.
module tb_ast_width_downsizer;

    localparam int DI = 128;
    localparam int DO = 64;
    localparam int K  = DI / DO;
    localparam int BO = DO / 8;

    typedef struct {
        logic [63:0] data;
        logic        sop;
        logic        eop;
        logic [2:0]  empty;
        logic [9:0]  ch;
    } beat_t;

    logic         clk, arst_n;
    logic [127:0] ast_data_i;
    logic         ast_startofpacket_i, ast_endofpacket_i, ast_valid_i;
    logic [3:0]   ast_empty_i;
    logic [9:0]   ast_channel_i;
    logic         ast_ready_o;
    logic [63:0]  ast_data_o;
    logic         ast_startofpacket_o, ast_endofpacket_o, ast_valid_o;
    logic [2:0]   ast_empty_o;
    logic [9:0]   ast_channel_o;
    logic         ast_ready_i;

    int     checks = 0;
    int     failures = 0;
    int     cyc = 0;
    beat_t  exp_q[$];
    beat_t  obs_log[$];
    int     fire_cyc[$];
    logic   bp_mode = 1'b0;
    logic [127:0] last_word;

    ast_width_downsizer dut (
        .clk_i(clk), .arst_n_i(arst_n),
        .ast_data_i(ast_data_i), .ast_startofpacket_i(ast_startofpacket_i),
        .ast_endofpacket_i(ast_endofpacket_i), .ast_valid_i(ast_valid_i),
        .ast_empty_i(ast_empty_i), .ast_channel_i(ast_channel_i),
        .ast_ready_o(ast_ready_o), .ast_data_o(ast_data_o),
        .ast_startofpacket_o(ast_startofpacket_o), .ast_endofpacket_o(ast_endofpacket_o),
        .ast_valid_o(ast_valid_o), .ast_empty_o(ast_empty_o),
        .ast_channel_o(ast_channel_o), .ast_ready_i(ast_ready_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Output-side ready: always 1, or random stalls of 1..10 cycles
    initial begin
        int stall_left;
        stall_left  = 0;
        ast_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (!bp_mode) begin
                ast_ready_i = 1'b1;
                stall_left  = 0;
            end else if (stall_left > 0) begin
                ast_ready_i = 1'b0;
                stall_left--;
            end else begin
                ast_ready_i = 1'b1;
                if ($urandom_range(0, 3) == 0) stall_left = $urandom_range(1, 10);
            end
        end
    end

    // Monitor: a beat seen with valid&ready at the negedge transfers on the next posedge
    initial begin
        logic        stall;
        logic        s_valid, s_sop, s_eop;
        logic [63:0] s_data;
        logic [2:0]  s_empty;
        logic [9:0]  s_ch;
        beat_t       e, o;
        stall = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!arst_n) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    check("hold_valid", 64'(ast_valid_o), 64'(s_valid));
                    check("hold_data", ast_data_o, s_data);
                    check("hold_sop", 64'(ast_startofpacket_o), 64'(s_sop));
                    check("hold_eop", 64'(ast_endofpacket_o), 64'(s_eop));
                    check("hold_empty", 64'(ast_empty_o), 64'(s_empty));
                    check("hold_channel", 64'(ast_channel_o), 64'(s_ch));
                end
                if (ast_valid_o && ast_ready_i) begin
                    o.data = ast_data_o; o.sop = ast_startofpacket_o; o.eop = ast_endofpacket_o;
                    o.empty = ast_empty_o; o.ch = ast_channel_o;
                    obs_log.push_back(o);
                    fire_cyc.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", 64'(1), 64'(0));
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_data", o.data, e.data);
                        check("beat_sop", 64'(o.sop), 64'(e.sop));
                        check("beat_eop", 64'(o.eop), 64'(e.eop));
                        check("beat_empty", 64'(o.empty), 64'(e.empty));
                        check("beat_channel", 64'(o.ch), 64'(e.ch));
                    end
                end
                stall   = ast_valid_o && !ast_ready_i;
                s_valid = ast_valid_o; s_data = ast_data_o; s_sop = ast_startofpacket_o;
                s_eop   = ast_endofpacket_o; s_empty = ast_empty_o; s_ch = ast_channel_o;
            end
        end
    end

    task automatic push_word(input logic [127:0] d, input logic s, input logic e,
                             input logic [3:0] emp, input logic [9:0] ch);
        int    nb;
        beat_t b;
        nb = e ? K - int'(emp) / BO : K;
        for (int i = 0; i < nb; i++) begin
            b.data  = d[DI-1-i*DO -: DO];
            b.sop   = s && (i == 0);
            b.eop   = e && (i == nb - 1);
            b.empty = (e && (i == nb - 1)) ? 3'(int'(emp) % BO) : 3'd0;
            b.ch    = ch;
            exp_q.push_back(b);
        end
    endtask

    // Present one word; returns after the accepting edge (+1) with valid left high
    task automatic send_word(input logic [127:0] d, input logic s, input logic e,
                             input logic [3:0] emp, input logic [9:0] ch, output int waits);
        logic acc;
        ast_data_i = d; ast_startofpacket_i = s; ast_endofpacket_i = e;
        ast_empty_i = emp; ast_channel_i = ch; ast_valid_i = 1'b1;
        waits = 0;
        forever begin
            @(negedge clk);
            acc = ast_ready_o;
            if (acc) push_word(d, s, e, emp, ch);
            @(posedge clk);
            #1;
            if (acc) break;
            waits++;
            if (waits > 300) begin
                check("accept_timeout", 64'(0), 64'(1));
                break;
            end
        end
    endtask

    task automatic send_pkt(input int n, input logic [9:0] ch, input logic [3:0] last_emp,
                            input logic chk_tput);
        int           w;
        logic [127:0] d;
        for (int i = 0; i < n; i++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            send_word(d, i == 0, i == n - 1,
                      (i == n - 1) ? last_emp : 4'($urandom_range(0, 15)), ch, w);
            if (chk_tput && i > 0) check("tput_ready_gap", 64'(w), 64'(1));
            last_word = d;
        end
        ast_valid_i = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("drain_queue", 64'(exp_q.size()), 64'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n0, w;
        int        bnd_emp[3]   = '{8, 7, 15};
        int        bnd_beats[3] = '{3, 4, 3};
        int        bnd_last[3]  = '{0, 7, 7};
        arst_n = 1'b0;
        ast_data_i = '0; ast_startofpacket_i = 1'b0; ast_endofpacket_i = 1'b0;
        ast_valid_i = 1'b0; ast_empty_i = '0; ast_channel_i = '0;

        repeat (2) @(negedge clk);
        check("rst_valid", 64'(ast_valid_o), 64'(0));
        check("rst_ready", 64'(ast_ready_o), 64'(0));
        check("rst_data", ast_data_o, 64'(0));
        check("rst_sop", 64'(ast_startofpacket_o), 64'(0));
        check("rst_eop", 64'(ast_endofpacket_o), 64'(0));
        check("rst_empty", 64'(ast_empty_o), 64'(0));
        check("rst_channel", 64'(ast_channel_o), 64'(0));
        @(posedge clk); #1 arst_n = 1'b1;
        @(posedge clk); #1;

        // One-word packet
        n0 = obs_log.size();
        send_word(128'h00112233_44556677_8899AABB_CCDDEEFF, 1'b1, 1'b1, 4'd0, 10'h155, w);
        ast_valid_i = 1'b0;
        drain();
        check("one_word_beats", 64'(obs_log.size() - n0), 64'(2));
        if (obs_log.size() >= n0 + 2) begin
            check("one_b1_data", obs_log[n0].data, 64'h0011223344556677);
            check("one_b1_sop", 64'(obs_log[n0].sop), 64'(1));
            check("one_b1_eop", 64'(obs_log[n0].eop), 64'(0));
            check("one_b1_ch", 64'(obs_log[n0].ch), 64'h155);
            check("one_b2_data", obs_log[n0+1].data, 64'h8899AABBCCDDEEFF);
            check("one_b2_sop", 64'(obs_log[n0+1].sop), 64'(0));
            check("one_b2_eop", 64'(obs_log[n0+1].eop), 64'(1));
            check("one_b2_empty", 64'(obs_log[n0+1].empty), 64'(0));
        end

        // Short tail: last word empty 10
        n0 = obs_log.size();
        send_pkt(3, 10'h2A, 4'd10, 1'b0);
        drain();
        check("tail_beats", 64'(obs_log.size() - n0), 64'(5));
        if (obs_log.size() >= n0 + 5) begin
            check("tail_eop", 64'(obs_log[n0+4].eop), 64'(1));
            check("tail_empty", 64'(obs_log[n0+4].empty), 64'(2));
            check("tail_data", obs_log[n0+4].data, last_word[127:64]);
        end

        // Empty boundaries on a 2-word packet
        for (int t = 0; t < 3; t++) begin
            n0 = obs_log.size();
            send_pkt(2, 10'(t + 1), 4'(bnd_emp[t]), 1'b0);
            drain();
            check("bnd_beats", 64'(obs_log.size() - n0), 64'(bnd_beats[t]));
            if (obs_log.size() > n0)
                check("bnd_last_empty", 64'(obs_log[obs_log.size()-1].empty), 64'(bnd_last[t]));
        end

        // Throughput: 10 back-to-back words, ready held high
        n0 = fire_cyc.size();
        send_pkt(10, 10'h0F0, 4'd0, 1'b1);
        drain();
        check("tput_beats", 64'(fire_cyc.size() - n0), 64'(20));
        if (fire_cyc.size() >= n0 + 20)
            check("tput_span", 64'(fire_cyc[n0+19] - fire_cyc[n0]), 64'(19));

        // Random backpressure
        bp_mode = 1'b1;
        for (int p = 0; p < 10; p++) begin
            send_pkt($urandom_range(1, 5), 10'($urandom), 4'($urandom_range(0, 15)), 1'b0);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        drain();
        bp_mode = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset after the first beat of a 3-word packet
        n0 = obs_log.size();
        send_word({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0, 4'd0, 10'h077, w);
        for (int i = 0; i < 50 && obs_log.size() == n0; i++) begin
            @(negedge clk);
            #1;
        end
        check("rst_mid_first_beat", 64'(obs_log.size() - n0), 64'(1));
        @(posedge clk);
        #1 arst_n = 1'b0;
        ast_valid_i = 1'b0;
        #1;
        check("rst_mid_valid", 64'(ast_valid_o), 64'(0));
        check("rst_mid_ready", 64'(ast_ready_o), 64'(0));
        check("rst_mid_data", ast_data_o, 64'(0));
        check("rst_mid_sop", 64'(ast_startofpacket_o), 64'(0));
        check("rst_mid_eop", 64'(ast_endofpacket_o), 64'(0));
        check("rst_mid_channel", 64'(ast_channel_o), 64'(0));
        exp_q.delete();
        @(posedge clk);
        #1 arst_n = 1'b1;
        n0 = obs_log.size();
        send_pkt(2, 10'h3, 4'd4, 1'b0);
        drain();
        check("post_rst_beats", 64'(obs_log.size() - n0), 64'(4));
        if (obs_log.size() >= n0 + 4) begin
            check("post_rst_sop", 64'(obs_log[n0].sop), 64'(1));
            check("post_rst_ch", 64'(obs_log[n0+3].ch), 64'h3);
            check("post_rst_empty", 64'(obs_log[n0+3].empty), 64'(4));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
